// File: rtl/gamma_lut_pkg.sv
// Shared types and helpers for the gamma LUT loader: FSM states, plane limits, LUT depth, plane selection.
package gamma_lut_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam int MAX_PLANES = 3;

   function automatic int lut_depth(input int width);
      return 1 << width;
   endfunction

   // Returns {found, index} of the lowest set bit of a plane mask.
   function automatic logic [2:0] lowest_plane(input logic [MAX_PLANES-1:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = MAX_PLANES - 1; i >= 0; i--) begin
         if (m[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   function automatic logic [MAX_PLANES-1:0] planes_above(input logic [1:0] p);
      logic [MAX_PLANES-1:0] r;
      case (p)
         2'd0:    r = 3'b110;
         2'd1:    r = 3'b100;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gamma_lut_loader.sv
// Streams 2**DATA_WIDTH table entries per selected plane into corrector LUTs; one write per accepted beat, one cycle later.
// src_ready is high only while loading; a stalled source stalls writes. Optional identity fill: GAMMA_LUT_RAMP_FILL_EN.
module gamma_lut_loader
   import gamma_lut_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int NUM_PLANES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [MAX_PLANES-1:0] plane_mask,
   input  logic                  abort,
`ifdef GAMMA_LUT_RAMP_FILL_EN
   input  logic                  ramp,
`endif
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_ready,
   output logic                  lut0wren,
   output logic [DATA_WIDTH-1:0] lut0val,
   output logic                  lut1wren,
   output logic [DATA_WIDTH-1:0] lut1val,
   output logic                  lut2wren,
   output logic [DATA_WIDTH-1:0] lut2val,
   output logic                  busy,
   output logic                  done,
   output logic                  abort_err,
   output logic                  gcen_out
);

   localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(lut_depth(DATA_WIDTH) - 1);
   localparam logic [MAX_PLANES-1:0] PLANE_EN  = MAX_PLANES'((1 << NUM_PLANES) - 1);

   state_t                  state;
   logic [DATA_WIDTH-1:0]   addr;
   logic [1:0]              plane;
   logic [MAX_PLANES-1:0]   mask_q;
   logic [MAX_PLANES-1:0]   wren_q;
   logic [DATA_WIDTH-1:0]   val_q [MAX_PLANES];

   logic [MAX_PLANES-1:0]   eff_mask;
   logic [2:0]              first_sel;
   logic [2:0]              next_sel;
   logic                    beat;
   logic [DATA_WIDTH-1:0]   beat_dat;

   assign eff_mask  = plane_mask & PLANE_EN;
   assign first_sel = lowest_plane(eff_mask);
   assign next_sel  = lowest_plane(mask_q & planes_above(plane));

`ifdef GAMMA_LUT_RAMP_FILL_EN
   logic ramp_q;

   assign src_ready = (state == ST_LOAD) && !ramp_q;
   assign beat      = (state == ST_LOAD) && (ramp_q || src_valid);
   assign beat_dat  = ramp_q ? addr : src_data;
`else
   assign src_ready = (state == ST_LOAD);
   assign beat      = src_valid && src_ready;
   assign beat_dat  = src_data;
`endif

   // Abort is checked ahead of the beat, so a beat presented alongside abort is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr      <= '0;
         plane     <= '0;
         mask_q    <= '0;
         wren_q    <= '0;
         for (int p = 0; p < MAX_PLANES; p++) val_q[p] <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         abort_err <= 1'b0;
         gcen_out  <= 1'b0;
`ifdef GAMMA_LUT_RAMP_FILL_EN
         ramp_q    <= 1'b0;
`endif
      end else begin
         wren_q <= '0;
         done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (first_sel[2]) begin
                     state     <= ST_LOAD;
                     plane     <= first_sel[1:0];
                     addr      <= '0;
                     mask_q    <= eff_mask;
                     busy      <= 1'b1;
                     gcen_out  <= 1'b0;
                     abort_err <= 1'b0;
`ifdef GAMMA_LUT_RAMP_FILL_EN
                     ramp_q    <= ramp;
`endif
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  abort_err <= 1'b1;
                  gcen_out  <= 1'b0;
               end else if (beat) begin
                  for (int p = 0; p < MAX_PLANES; p++) begin
                     if (p == int'(plane)) begin
                        wren_q[p] <= 1'b1;
                        val_q[p]  <= beat_dat;
                     end
                  end
                  if (addr == LAST_ADDR) begin
                     addr <= '0;
                     if (next_sel[2]) plane <= next_sel[1:0];
                     else             state <= ST_FINISH;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            ST_FINISH: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               if (abort) begin
                  abort_err <= 1'b1;
                  gcen_out  <= 1'b0;
               end else begin
                  done     <= 1'b1;
                  gcen_out <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign lut0wren = wren_q[0];
   assign lut1wren = wren_q[1];
   assign lut2wren = wren_q[2];
   assign lut0val  = val_q[0];
   assign lut1val  = val_q[1];
   assign lut2val  = val_q[2];

endmodule

// File: tb/tb_gamma_lut_loader.sv
// Directed/randomized bench for gamma_lut_loader at DATA_WIDTH=4, NUM_PLANES=3 against a queue-based write model.
module tb_gamma_lut_loader;
   localparam int DW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    plane_mask = '0;
   logic          abort = 1'b0;
`ifdef GAMMA_LUT_RAMP_FILL_EN
   logic          ramp = 1'b0;
`endif
   logic          src_valid = 1'b0;
   logic [DW-1:0] src_data = '0;
   logic          src_ready;
   logic          lut0wren, lut1wren, lut2wren;
   logic [DW-1:0] lut0val, lut1val, lut2val;
   logic          busy, done, abort_err, gcen_out;

   gamma_lut_loader #(.DATA_WIDTH(DW), .NUM_PLANES(3)) dut (
      .clk(clk), .rst(rst), .start(start), .plane_mask(plane_mask), .abort(abort),
`ifdef GAMMA_LUT_RAMP_FILL_EN
      .ramp(ramp),
`endif
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .lut0wren(lut0wren), .lut0val(lut0val),
      .lut1wren(lut1wren), .lut1val(lut1val),
      .lut2wren(lut2wren), .lut2val(lut2val),
      .busy(busy), .done(done), .abort_err(abort_err), .gcen_out(gcen_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   // Observed writes per plane, with the cycle each was seen.
   int wq[3][$];
   int wcyc[3][$];
   int expq[3][$];
   int sent[$];
   int done_cnt = 0;
   int done_cyc = 0;

   always @(negedge clk) begin
      logic [2:0] wv;
      int         vv[3];
      wv = {lut2wren, lut1wren, lut0wren};
      vv[0] = int'(lut0val);
      vv[1] = int'(lut1val);
      vv[2] = int'(lut2val);
      for (int p = 0; p < 3; p++) begin
         if (wv[p]) begin
            wq[p].push_back(vv[p]);
            wcyc[p].push_back(cyc);
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int p = 0; p < 3; p++) begin
         wq[p].delete();
         wcyc[p].delete();
         expq[p].delete();
      end
      sent.delete();
      done_cnt = 0;
   endtask

   task automatic do_start(input logic [2:0] m);
      start = 1'b1;
      plane_mask = m;
      tick();
      start = 1'b0;
      plane_mask = $urandom_range(0, 7);
   endtask

   // mode 0: continuous, 1: valid toggles every cycle, 2: random valid
   task automatic send_beats(input int n, input int mode, input bit seq);
      int got = 0;
      int budget = 0;
      bit v = 1'b0;
      while (got < n && budget < 300) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = ~v;
            default: v = 1'($urandom_range(0, 1));
         endcase
         src_valid = v;
         src_data  = seq ? DW'(got) : DW'($urandom);
         if (v && src_ready) begin
            sent.push_back(int'(src_data));
            got++;
         end
         tick();
         budget++;
      end
      src_valid = 1'b0;
      check("beat_budget", got, n);
   endtask

   // Accepted beats fill selected planes in ascending order, DEPTH entries each.
   task automatic build_expected(input logic [2:0] m);
      int i = 0;
      for (int p = 0; p < 3; p++) begin
         if (m[p]) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (i < sent.size()) begin
                  expq[p].push_back(sent[i]);
                  i++;
               end
            end
         end
      end
   endtask

   task automatic cmp_plane(input int p);
      int n;
      check($sformatf("p%0d_count", p), wq[p].size(), expq[p].size());
      n = (wq[p].size() < expq[p].size()) ? wq[p].size() : expq[p].size();
      for (int k = 0; k < n; k++)
         check($sformatf("p%0d_val%0d", p, k), wq[p][k], expq[p][k]);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_src_ready", int'(src_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_abort_err", int'(abort_err), 0);
      check("rst_gcen", int'(gcen_out), 0);
      check("rst_wren", int'({lut2wren, lut1wren, lut0wren}), 0);
      check("rst_vals", int'({lut2val, lut1val, lut0val}), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Single plane, continuous sequential data
      clear_model();
      do_start(3'b001);
      check("t1_busy", int'(busy), 1);
      check("t1_gcen_low", int'(gcen_out), 0);
      check("t1_ready", int'(src_ready), 1);
      send_beats(16, 0, 1'b1);
      repeat (4) tick();
      build_expected(3'b001);
      cmp_plane(0);
      check("t1_p1_none", wq[1].size(), 0);
      check("t1_p2_none", wq[2].size(), 0);
      if (wcyc[0].size() == 16) begin
         check("t1_consecutive", wcyc[0][15] - wcyc[0][0], 15);
         check("t1_done_timing", done_cyc, wcyc[0][15] + 1);
      end else begin
         check("t1_wcount", wcyc[0].size(), 16);
      end
      check("t1_done_cnt", done_cnt, 1);
      check("t1_gcen_high", int'(gcen_out), 1);
      check("t1_busy_low", int'(busy), 0);

      // Planes 0 and 2, toggling valid, random data
      clear_model();
      do_start(3'b101);
      send_beats(32, 1, 1'b0);
      repeat (4) tick();
      build_expected(3'b101);
      cmp_plane(0);
      cmp_plane(2);
      check("t2_p1_none", wq[1].size(), 0);
      check("t2_done_cnt", done_cnt, 1);

      // Abort after 7 beats on plane 0
      clear_model();
      do_start(3'b011);
      send_beats(7, 0, 1'b0);
      src_valid = 1'b1;
      src_data  = DW'($urandom);
      abort     = 1'b1;
      tick();
      abort     = 1'b0;
      src_valid = 1'b0;
      tick();
      build_expected(3'b011);
      cmp_plane(0);
      check("t3_p1_none", wq[1].size(), 0);
      check("t3_abort_err", int'(abort_err), 1);
      check("t3_gcen", int'(gcen_out), 0);
      check("t3_busy", int'(busy), 0);
      check("t3_no_done", done_cnt, 0);
      check("t3_ready", int'(src_ready), 0);

      // Restart after abort clears abort_err and starts plane 0 afresh
      clear_model();
      do_start(3'b001);
      check("t4_err_cleared", int'(abort_err), 0);
      send_beats(16, 2, 1'b0);
      repeat (4) tick();
      build_expected(3'b001);
      cmp_plane(0);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_gcen", int'(gcen_out), 1);

      // start and abort together in IDLE: start wins
      clear_model();
      abort = 1'b1;
      do_start(3'b100);
      abort = 1'b0;
      check("t5_busy", int'(busy), 1);
      check("t5_abort_err", int'(abort_err), 0);
      send_beats(16, 2, 1'b0);
      repeat (4) tick();
      build_expected(3'b100);
      cmp_plane(2);
      check("t5_done_cnt", done_cnt, 1);

      // Empty mask: done next cycle, no writes, gcen unchanged
      clear_model();
      do_start(3'b000);
      check("t6_done", int'(done), 1);
      check("t6_busy", int'(busy), 0);
      tick();
      check("t6_done_pulse", int'(done), 0);
      repeat (3) tick();
      check("t6_writes", wq[0].size() + wq[1].size() + wq[2].size(), 0);
      check("t6_done_cnt", done_cnt, 1);
      check("t6_gcen", int'(gcen_out), 1);

      // start during a busy load is ignored
      clear_model();
      do_start(3'b010);
      send_beats(5, 0, 1'b0);
      do_start(3'b001);
      check("t7_busy", int'(busy), 1);
      send_beats(11, 2, 1'b0);
      repeat (4) tick();
      build_expected(3'b010);
      cmp_plane(1);
      check("t7_p0_none", wq[0].size(), 0);
      check("t7_done_cnt", done_cnt, 1);

      // Asynchronous reset mid-load on plane 1
      clear_model();
      do_start(3'b010);
      send_beats(5, 0, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      check("t8_busy", int'(busy), 0);
      check("t8_ready", int'(src_ready), 0);
      check("t8_wren", int'({lut2wren, lut1wren, lut0wren}), 0);
      check("t8_vals", int'({lut2val, lut1val, lut0val}), 0);
      check("t8_gcen", int'(gcen_out), 0);
      check("t8_abort_err", int'(abort_err), 0);
      check("t8_done", int'(done), 0);
      src_valid = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (4) tick();
      check("t8_ready_idle", int'(src_ready), 0);
      src_valid = 1'b0;
      build_expected(3'b010);
      cmp_plane(1);
      check("t8_no_done", done_cnt, 0);

`ifdef GAMMA_LUT_RAMP_FILL_EN
      // Identity fill on plane 1
      clear_model();
      ramp = 1'b1;
      do_start(3'b010);
      ramp = 1'b0;
      check("t9_ready", int'(src_ready), 0);
      src_valid = 1'b1;
      repeat (8) tick();
      check("t9_ready_mid", int'(src_ready), 0);
      repeat (12) tick();
      src_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) expq[1].push_back(k);
      cmp_plane(1);
      if (wcyc[1].size() == DEPTH)
         check("t9_consecutive", wcyc[1][DEPTH-1] - wcyc[1][0], DEPTH - 1);
      check("t9_done_cnt", done_cnt, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/gamma_lut_loader.md
GAMMA_LUT_LOADER -- requirements
Module: gamma_lut_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, LUT entry width and address width; LUT depth = 2**DATA_WIDTH.
REQ-002 SHALL have parameter NUM_PLANES, default 3, number of color-plane LUTs driven (1..3).
REQ-003 SHALL have port clk  in  1  single system clock, all logic rising-edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle load request.
REQ-006 SHALL have port plane_mask  in  3  planes to load; bit n selects plane n; bits >= NUM_PLANES ignored.
REQ-007 SHALL have port abort  in  1  terminate the load in progress.
REQ-008 SHALL have ports src_valid  in  1, src_data  in  DATA_WIDTH, src_ready  out  1  table-entry stream, valid/ready.
REQ-009 SHALL have ports lutNwren  out  1 and lutNval  out  DATA_WIDTH, for N < NUM_PLANES; corrector LUT write port, address auto-increments in the corrector per pulse.
REQ-010 SHALL have ports busy  out  1, done  out  1 (pulse), abort_err  out  1 (sticky), gcen_out  out  1  gamma enable to the corrector.

Function
REQ-011 SHALL implement states IDLE, LOAD, FINISH.
REQ-012 IDLE: start with masked-in planes nonzero -> LOAD at lowest selected plane, addr=0, busy=1, gcen_out=0, abort_err cleared.
REQ-013 IDLE: start with effective mask zero -> done pulse next cycle, no writes, gcen_out unchanged.
REQ-014 src_ready SHALL be 1 only in LOAD, combinationally from state.
REQ-015 Each src_valid&&src_ready beat SHALL produce exactly one lutNwren pulse on the current plane one cycle later, lutNval = src_data registered; other planes' wren stay 0.
REQ-016 addr SHALL increment per accepted beat; at addr = 2**DATA_WIDTH-1 it wraps to 0 and the plane advances to the next selected plane, skipping unselected ones.
REQ-017 After the last beat of the last selected plane -> FINISH; FINISH lasts one cycle after the final lutNwren pulse; then IDLE, done=1 for that one cycle, busy=0, gcen_out=1.
REQ-018 start while busy SHALL be ignored; plane_mask SHALL be sampled only on accepted start.
REQ-019 abort in LOAD or FINISH SHALL return to IDLE next cycle; the beat presented in the abort cycle is not accepted; abort_err=1, gcen_out=0, no done pulse; a wren already registered still issues.
REQ-020 abort and start together in IDLE: start wins, abort ignored.
REQ-021 src_valid low SHALL stall without timeout; no wren while stalled.
REQ-022 Total writes per plane SHALL be exactly 2**DATA_WIDTH so the corrector address returns to 0.

Reset
REQ-023 On rst: state IDLE, addr 0, plane 0, src_ready 0, all lutNwren 0, all lutNval 0, busy 0, done 0, abort_err 0, gcen_out 0.
REQ-024 rst mid-load SHALL take effect asynchronously; no further wren pulses.

Configuration
REQ-025 Macro GAMMA_LUT_RAMP_FILL_EN: when defined, input ramp (1 bit, sampled with start) SHALL select identity fill: in LOAD, writes issue every cycle with lutNval = addr, src_ready held 0, src_data ignored.
REQ-026 Without GAMMA_LUT_RAMP_FILL_EN the ramp port and ramp logic SHALL be absent; all loads use the src stream.

Structure
REQ-027 State enumeration, NUM_PLANES max (3) and the LUT-depth function SHALL live in shared package gamma_lut_pkg.
REQ-028 No sub-module; address counter, plane sequencer and FSM SHALL be a single module.

Verification (DATA_WIDTH=4, NUM_PLANES=3)
REQ-029 start, mask=3'b001, 16 beats 0..15 continuous -> lut0wren 16 consecutive cycles, lut0val 0..15, done 1 cycle after last wren, gcen_out 0->1.
REQ-030 mask=3'b101, 32 beats with src_valid toggling every cycle -> 16 writes on plane 0 then 16 on plane 2, lut1wren never high, done once.
REQ-031 abort after 7 beats on plane 0 -> exactly 7 lut0wren pulses, abort_err=1, gcen_out=0, busy=0, no done; next start clears abort_err.
REQ-032 start with mask=3'b000 -> done pulse next cycle, zero writes; start pulsed during busy load -> ignored, write count unchanged.
REQ-033 rst asserted after 5 beats on plane 1 -> all outputs at reset values immediately, no wren afterward.
REQ-034 With GAMMA_LUT_RAMP_FILL_EN, ramp=1, mask=3'b010 -> 16 back-to-back lut1wren, lut1val 0..15, src_ready stays 0.
